// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neuron datapath (MAC accumulator and
// the downstream ReLU stage).
//   NN_DATA_WIDTH : signed operand/result width (Q8.8 at defaults)
//   NN_ACC_WIDTH  : signed accumulator width
//   NN_FRAC_BITS  : fractional bits of the fixed-point format
//   mac_state_t   : MAC sequencing states (ACCUM, FLUSH, HOLD)
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_ACC_WIDTH  = 40;
    localparam int NN_FRAC_BITS  = 8;

    // Explicit encodings keep the state register bit-compatible with the
    // original two-bit state constants.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/sat_narrow.sv
// sat_narrow: combinational arithmetic right shift followed by signed
// saturation to a narrower width.
//   din  : IN_WIDTH signed input
//   dout : OUT_WIDTH signed output, floor(din / 2^SHIFT) clamped to
//          [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
module sat_narrow #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    logic signed [IN_WIDTH-1:0]        shifted;
    logic        [IN_WIDTH-OUT_WIDTH:0] upper;

    // Arithmetic shift gives floor semantics for negative values.
    assign shifted = din >>> SHIFT;

    // The value fits when every bit from the output sign bit upward is a copy
    // of the input sign bit.
    assign upper = shifted[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        dout = shifted[OUT_WIDTH-1:0];
        if (!((upper == '0) || (upper == '1))) begin
            if (shifted[IN_WIDTH-1]) begin
                dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: two-stage pipelined multiply-accumulate producing one
// saturated fixed-point dot product per vector.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake (in_ready depends on state only)
//   in_data, in_weight  : signed operands
//   in_last             : final beat of the current vector
//   out_valid/out_ready : result handshake towards the ReLU stage
//   out_data            : shifted, saturated dot product (held while stalled)
module mac_accumulator
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int ACC_WIDTH  = NN_ACC_WIDTH,
    parameter int FRAC_BITS  = NN_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] in_weight,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    mac_state_t state;
    mac_state_t state_next;

    logic                         accept;
    logic signed [PROD_WIDTH-1:0] data_ext;
    logic signed [PROD_WIDTH-1:0] weight_ext;
    logic signed [PROD_WIDTH-1:0] product;

    logic                         p1_valid;
    logic                         p1_last;
    logic signed [PROD_WIDTH-1:0] p1_prod;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] narrowed;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Widen before multiplying so the full-precision product is kept.
    assign data_ext   = PROD_WIDTH'(in_data);
    assign weight_ext = PROD_WIDTH'(in_weight);
    assign product    = data_ext * weight_ext;

    // Stage 1: register product and last flag of each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            p1_prod  <= '0;
        end else begin
            p1_valid <= accept;
            if (accept) begin
                p1_prod <= product;
                p1_last <= in_last;
            end
        end
    end

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){p1_prod[PROD_WIDTH-1]}}, p1_prod};
    assign sum      = acc + prod_ext;

    sat_narrow #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH),
        .SHIFT     (FRAC_BITS)
    ) u_sat_narrow (
        .din  (sum),
        .dout (narrowed)
    );

    // Stage 2: accumulate; the last product is folded straight into the
    // result so the accumulator is free again on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
        end else if (p1_valid) begin
            if (p1_last) begin
                out_data <= narrowed;
                acc      <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // FLUSH lasts exactly the one cycle the last product spends in stage 1.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && in_last) state_next = FLUSH;
            FLUSH:   state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed self-checking bench for mac_accumulator with
// hand-computed Q8.8 expected results.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_weight;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int checks;
    int failures;

    mac_accumulator #(
        .DATA_WIDTH (16),
        .ACC_WIDTH  (40),
        .FRAC_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic [15:0] w, input logic last);
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_last   = last;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h5A5A;
        in_weight = 16'hA5A5;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data   = 16'($urandom);
            in_weight = 16'($urandom);
            in_last   = 1'($urandom);
            tick();
        end
        in_last = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last beat.
    task automatic finish_vector(input string tag, input logic [15:0] exp);
        chk({tag, "_flush_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_flush_ready"}, 16'(in_ready), 16'd0);
        tick();
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_done_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 16'(in_ready), 16'd1);

        // Single beat: 2.0 * 1.5 = 3.0
        beat(16'h0200, 16'h0180, 1'b1);
        finish_vector("single", 16'h0300);

        // 1.0 - 2.0 + 0.5 = -0.5
        beat(16'h0100, 16'h0100, 1'b0);
        beat(16'h0200, 16'hFF00, 1'b0);
        beat(16'h0080, 16'h0100, 1'b1);
        finish_vector("three", 16'hFF80);

        // Positive saturation
        for (int i = 0; i < 4; i++) beat(16'h7FFF, 16'h7FFF, 1'(i == 3));
        finish_vector("sat_pos", 16'h7FFF);

        // Negative saturation
        for (int i = 0; i < 4; i++) beat(16'h8000, 16'h7FFF, 1'(i == 3));
        finish_vector("sat_neg", 16'h8000);

        // -1/65536 floors to -1/256
        beat(16'h0001, 16'hFFFF, 1'b1);
        finish_vector("floor", 16'hFFFF);

        // Gapped vector gives the same result as back-to-back
        beat(16'h0100, 16'h0100, 1'b0);
        idle(1);
        beat(16'h0200, 16'hFF00, 1'b0);
        idle(3);
        beat(16'h0080, 16'h0100, 1'b1);
        finish_vector("gaps", 16'hFF80);

        // Backpressure: 1.0 * 1.25 = 1.25 held for five stalled cycles
        beat(16'h0100, 16'h0140, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 16'(out_valid), 16'd1);
            chk("stall_ready", 16'(in_ready), 16'd0);
            chk("stall_data", out_data, 16'h0140);
            in_valid = 1'b1;
            in_data  = 16'h1111;
            in_weight = 16'h2222;
            in_last  = 1'b1;
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_valid", 16'(out_valid), 16'd0);
        chk("stall_release_ready", 16'(in_ready), 16'd1);

        // Reset mid-vector discards the partial sum
        beat(16'h0100, 16'h0100, 1'b0);
        beat(16'h0200, 16'hFF00, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 16'(out_valid), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
        beat(16'h0100, 16'h0100, 1'b1);
        finish_vector("after_rst", 16'h0100);

        // Reset in HOLD discards the pending result
        beat(16'h0200, 16'h0180, 1'b1);
        tick();
        chk("hold_pre_valid", 16'(out_valid), 16'd1);
        #2;
        rst_n = 1'b0;
        #2;
        chk("hold_rst_valid", 16'(out_valid), 16'd0);
        chk("hold_rst_data", out_data, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("hold_rst_ready", 16'(in_ready), 16'd1);
        beat(16'h0080, 16'h0100, 1'b1);
        finish_vector("after_hold_rst", 16'h0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
